// File: rtl/mux_sel_arbiter_pkg.sv
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared types and constants for the 4-channel mux-select
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int NUM_CH      = 4;
    localparam int TIMEOUT_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_arbiter_if.sv
// ============================================================================
// Module      : mux_sel_arbiter_if
// Description : Request/grant and mux-select bundle between requesters and
//               the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_sel_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              done;
    logic [NUM_CH-1:0] gnt;
    logic              S0;
    logic              S1;
    logic              busy;
    logic              tmo;

    modport master (
        output req, done,
        input  gnt, S0, S1, busy, tmo
    );

    modport slave (
        input  req, done,
        output gnt, S0, S1, busy, tmo
    );

endinterface

`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotating-priority picker; first set request
//               searching upward from ptr, modulo 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux_arb_pkg::*;
(
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [1:0]        ptr,
    output logic      [1:0]        index,
    output logic                   any
);

    logic [1:0] cand;

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        index = 2'd0;
        any   = |req;
        cand  = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                index = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Two-state round-robin arbiter driving the select lines of a
//               4:1 mux, with done/drop/timeout grant termination.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux_sel_arbiter_if.slave  bus
);

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              tmo_q, tmo_d;

    logic [1:0]        pick_idx;
    logic              pick_any;
    logic              req_held;
    logic              at_limit;
    logic              grant_exit;
    logic              exit_by_tmo;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign req_held    = bus.req[sel_q];
    assign at_limit    = (cnt_q == CNT_LAST);
    assign grant_exit  = (state_q == GRANT) && (bus.done || !req_held || at_limit);
    // Timeout pulse only when neither done nor a dropped request also ended it.
    assign exit_by_tmo = (state_q == GRANT) && at_limit && !bus.done && req_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    ptr_d   = pick_idx + 2'd1;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                if (grant_exit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        busy_d = busy_q;
        tmo_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d  = idx_to_onehot(pick_idx);
                    sel_d  = pick_idx;
                    busy_d = 1'b1;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (grant_exit) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    tmo_d  = exit_by_tmo;
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.S0   = sel_q[1];
    assign bus.S1   = sel_q[0];
    assign bus.busy = busy_q;
    assign bus.tmo  = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Directed-vector bench for mux_sel_arbiter with TIMEOUT=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_sel_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed/expected packed as {gnt[3:0], S0, S1, busy, tmo}.
    task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic t);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {bus.gnt, bus.S0, bus.S1, bus.busy, bus.tmo};
        exp = {g, s, b, t};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        tick();
        chk("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_noreq", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Single grant ended by done
        bus.req = 4'b0100;
        tick();
        chk("grant_i2", 4'b0100, 2'b10, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        chk("done_exit", 4'b0000, 2'b10, 1'b0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();
        chk("idle_sel_hold", 4'b0000, 2'b10, 1'b0, 1'b0);

        // Fresh reset so the round-robin starts at channel 0
        rst_n = 1'b0;
        #1;
        chk("reset_again", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_grant_%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            bus.done = 1'b1;
            tick();
            chk($sformatf("rr_gap_%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
            bus.done = 1'b0;
        end

        // Timeout after exactly 8 grant cycles (ptr is now 1)
        bus.req = 4'b0010;
        tick();
        chk("tmo_grant_c1", 4'b0010, 2'b01, 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk($sformatf("tmo_grant_c%0d", c), 4'b0010, 2'b01, 1'b1, 1'b0);
        end
        tick();
        chk("tmo_pulse", 4'b0000, 2'b01, 1'b0, 1'b1);
        tick();
        chk("tmo_regrant", 4'b0010, 2'b01, 1'b1, 1'b0);

        // Timeout edge coinciding with done suppresses tmo
        for (int c = 2; c <= 8; c++) begin
            tick();
        end
        chk("coinc_last_cycle", 4'b0010, 2'b01, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        chk("coinc_no_tmo", 4'b0000, 2'b01, 1'b0, 1'b0);
        bus.done = 1'b0;

        // Dropped request ends grant without tmo (ptr is now 2)
        bus.req = 4'b0001;
        tick();
        chk("drop_grant", 4'b0001, 2'b00, 1'b1, 1'b0);
        tick();
        chk("drop_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk("drop_exit", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Reset mid-grant aborts immediately
        bus.req = 4'b1000;
        tick();
        chk("pre_abort_grant", 4'b1000, 2'b11, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_immediate", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        chk("abort_no_tmo", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        tick();
        chk("post_reset_ch0", 4'b0001, 2'b00, 1'b1, 1'b0);
        tick();
        chk("ignore_other_req", 4'b0001, 2'b00, 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        chk("post_reset_gap", 4'b0000, 2'b00, 1'b0, 1'b0);
        bus.done = 1'b0;
        tick();
        chk("post_reset_ch3", 4'b1000, 2'b11, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
